bb8051_operand_fetch: RTL and testbench

Parametrised operand-fetch stage between the bb8051 decoder and ALU. It accepts a per-channel source-select vector from the decoder and resolves each channel to a data word. Sources are accumulator, B register, instruction constants, direct internal-RAM reads and, optionally, indirect internal-RAM reads. Operands are latched and presented to the ALU under a valid/ready handshake, so multi-cycle RAM fetches stall the decoder cleanly.

---
 rtl/bb8051_pkg.sv | 29 ++
 rtl/bb8051_src_mux.sv | 48 ++++
 rtl/bb8051_operand_fetch.sv | 190 +++++++++++++++++++
 tb/tb_bb8051_operand_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb8051_pkg.sv
// Purpose : shared select-code constants and operand-fetch FSM encoding for the bb8051 core.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   BB8051_SEL_W          width of one per-channel source-select field
//   BB8051_SRC_SEL_*      source-select codes driven by the decoder
//   bb8051_opf_state_e    operand-fetch sequencer states
package bb8051_pkg;

  localparam int BB8051_SEL_W = 3;

  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_NO       = 3'd0;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_ACC      = 3'd1;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_B        = 3'd2;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_CONST2   = 3'd3;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_CONST3   = 3'd4;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_DIRECT   = 3'd5;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_INDIRECT = 3'd6;
  localparam logic [BB8051_SEL_W-1:0] BB8051_SRC_SEL_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    BB8051_ST_IDLE  = 2'd0,
    BB8051_ST_ISSUE = 2'd1,
    BB8051_ST_CAPT  = 2'd2,
    BB8051_ST_DONE  = 2'd3
  } bb8051_opf_state_e;

endpackage

// File: rtl/bb8051_src_mux.sv
// Purpose : per-channel decode of one source-select code into an immediate operand.
// Latency : combinational.
// Backpressure: none; the caller decides when the result is latched.
//
// Ports:
//   i_sel          select code for this channel
//   i_acc/i_b      current ACC and B register values
//   i_op2/i_op3    instruction constant bytes
//   o_dat          operand for non-RAM codes (zero for RAM and reserved codes)
//   o_err          code is reserved
//   o_ram          code needs an internal-RAM fetch
// Build option: BB8051_OPFETCH_INDIRECT_EN makes code 6 a RAM fetch; otherwise it is reserved.
module bb8051_src_mux
  import bb8051_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [BB8051_SEL_W-1:0] i_sel,
  input  logic [DATA_W-1:0]       i_acc,
  input  logic [DATA_W-1:0]       i_b,
  input  logic [DATA_W-1:0]       i_op2,
  input  logic [DATA_W-1:0]       i_op3,
  output logic [DATA_W-1:0]       o_dat,
  output logic                    o_err,
  output logic                    o_ram
);

  always_comb begin
    o_dat = '0;
    o_err = 1'b0;
    o_ram = 1'b0;
    case (i_sel)
      BB8051_SRC_SEL_NO:       o_dat = '0;
      BB8051_SRC_SEL_ACC:      o_dat = i_acc;
      BB8051_SRC_SEL_B:        o_dat = i_b;
      BB8051_SRC_SEL_CONST2:   o_dat = i_op2;
      BB8051_SRC_SEL_CONST3:   o_dat = i_op3;
      BB8051_SRC_SEL_DIRECT:   o_ram = 1'b1;
`ifdef BB8051_OPFETCH_INDIRECT_EN
      BB8051_SRC_SEL_INDIRECT: o_ram = 1'b1;
`else
      BB8051_SRC_SEL_INDIRECT: o_err = 1'b1;
`endif
      default:                 o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/bb8051_operand_fetch.sv
// Purpose : operand-fetch stage between bb8051 decoder and ALU; resolves NUM_SRC channels.
// Latency : accept to out_valid = 1 + 2*direct + 4*indirect cycles (RAM reads serialised).
// Backpressure: req_ready only in IDLE; DONE holds all outputs until out_valid && out_ready.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             abort current transaction (back to IDLE, src_out kept)
//   i_req_valid/o_req_ready   decoder request handshake
//   i_src_sel           channel i select in bits [3i+2:3i]
//   i_op2_in/i_op3_in   instruction constants; i_acc_in/i_b_reg_in ACC and B values
//   o_ram_rd_en/o_ram_rd_addr/i_ram_rd_data   internal-RAM read port (data one cycle later)
//   o_src_out           channel i operand in bits [DATA_W*(i+1)-1:DATA_W*i]
//   o_out_valid/i_out_ready   ALU handshake
//   o_sel_err           a reserved select code was seen in the current transaction
// Build option: BB8051_OPFETCH_INDIRECT_EN enables code 6 (ram[ram[op2]]) and the pointer path.
module bb8051_operand_fetch
  import bb8051_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int NUM_SRC = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic [BB8051_SEL_W*NUM_SRC-1:0] i_src_sel,
  input  logic [DATA_W-1:0]               i_op2_in,
  input  logic [DATA_W-1:0]               i_op3_in,
  input  logic [DATA_W-1:0]               i_acc_in,
  input  logic [DATA_W-1:0]               i_b_reg_in,
  output logic                            o_ram_rd_en,
  output logic [ADDR_W-1:0]               o_ram_rd_addr,
  input  logic [DATA_W-1:0]               i_ram_rd_data,
  output logic [DATA_W*NUM_SRC-1:0]       o_src_out,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic                            o_sel_err
);

  bb8051_opf_state_e          r_state;
  logic [DATA_W-1:0]          r_op2;
  logic [NUM_SRC-1:0]         r_pend;      // RAM channels still to be fetched
  logic [DATA_W*NUM_SRC-1:0]  r_src;
  logic                       r_sel_err;

  logic [DATA_W*NUM_SRC-1:0]  w_mux_dat;
  logic [NUM_SRC-1:0]         w_mux_err;
  logic [NUM_SRC-1:0]         w_mux_ram;
  logic [NUM_SRC-1:0]         w_cur_oh;    // channel being fetched (lowest pending)
  logic [NUM_SRC-1:0]         w_pend_next;
  logic                       w_ptr_rd;    // the read in flight returns a pointer

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_mux
    bb8051_src_mux #(
      .DATA_W (DATA_W)
    ) u_mux (
      .i_sel  (i_src_sel[BB8051_SEL_W*g +: BB8051_SEL_W]),
      .i_acc  (i_acc_in),
      .i_b    (i_b_reg_in),
      .i_op2  (i_op2_in),
      .i_op3  (i_op3_in),
      .o_dat  (w_mux_dat[DATA_W*g +: DATA_W]),
      .o_err  (w_mux_err[g]),
      .o_ram  (w_mux_ram[g])
    );
  end

  // Scan from the top down so the lowest pending channel wins: ascending fetch order.
  always_comb begin
    w_cur_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_cur_oh    = '0;
        w_cur_oh[i] = 1'b1;
      end
    end
  end

  assign w_pend_next = r_pend & ~w_cur_oh;

`ifdef BB8051_OPFETCH_INDIRECT_EN
  logic [NUM_SRC-1:0] r_ind;        // channels that are indirect, latched at accept
  logic               r_ptr_phase;  // pointer captured, data read is next
  logic [ADDR_W-1:0]  r_ptr;
  logic [NUM_SRC-1:0] w_ind_sel;
  logic               w_cur_ind;

  always_comb begin
    w_ind_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ind_sel[i] = (i_src_sel[BB8051_SEL_W*i +: BB8051_SEL_W] == BB8051_SRC_SEL_INDIRECT);
    end
  end

  assign w_cur_ind     = |(r_ind & w_cur_oh);
  assign w_ptr_rd      = w_cur_ind & ~r_ptr_phase;
  // First read of any RAM channel uses op2; only the second indirect read uses the pointer.
  assign o_ram_rd_addr = (w_cur_ind && r_ptr_phase) ? r_ptr : r_op2[ADDR_W-1:0];
`else
  assign w_ptr_rd      = 1'b0;
  assign o_ram_rd_addr = r_op2[ADDR_W-1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= BB8051_ST_IDLE;
      r_op2     <= '0;
      r_pend    <= '0;
      r_src     <= '0;
      r_sel_err <= 1'b0;
`ifdef BB8051_OPFETCH_INDIRECT_EN
      r_ind       <= '0;
      r_ptr_phase <= 1'b0;
      r_ptr       <= '0;
`endif
    end else if (i_flush) begin
      // src_out is deliberately kept; any RAM data still in flight is never captured.
      r_state   <= BB8051_ST_IDLE;
      r_pend    <= '0;
      r_sel_err <= 1'b0;
`ifdef BB8051_OPFETCH_INDIRECT_EN
      r_ptr_phase <= 1'b0;
`endif
    end else begin
      case (r_state)
        BB8051_ST_IDLE: begin
          if (i_req_valid) begin
            r_op2     <= i_op2_in;
            r_pend    <= w_mux_ram;
            r_sel_err <= |w_mux_err;
            // RAM channels keep their old value until their own read completes.
            for (int i = 0; i < NUM_SRC; i++) begin
              if (!w_mux_ram[i]) begin
                r_src[DATA_W*i +: DATA_W] <= w_mux_dat[DATA_W*i +: DATA_W];
              end
            end
`ifdef BB8051_OPFETCH_INDIRECT_EN
            r_ind       <= w_ind_sel;
            r_ptr_phase <= 1'b0;
`endif
            r_state <= (|w_mux_ram) ? BB8051_ST_ISSUE : BB8051_ST_DONE;
          end
        end

        BB8051_ST_ISSUE: begin
          r_state <= BB8051_ST_CAPT;
        end

        BB8051_ST_CAPT: begin
          if (w_ptr_rd) begin
`ifdef BB8051_OPFETCH_INDIRECT_EN
            r_ptr       <= i_ram_rd_data[ADDR_W-1:0];
            r_ptr_phase <= 1'b1;
`endif
            r_state <= BB8051_ST_ISSUE;
          end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (w_cur_oh[i]) begin
                r_src[DATA_W*i +: DATA_W] <= i_ram_rd_data;
              end
            end
            r_pend <= w_pend_next;
`ifdef BB8051_OPFETCH_INDIRECT_EN
            r_ptr_phase <= 1'b0;
`endif
            r_state <= (|w_pend_next) ? BB8051_ST_ISSUE : BB8051_ST_DONE;
          end
        end

        BB8051_ST_DONE: begin
          if (i_out_ready) begin
            r_state <= BB8051_ST_IDLE;
          end
        end

        default: r_state <= BB8051_ST_IDLE;
      endcase
    end
  end

  // All outputs are direct decodes of registered state.
  assign o_req_ready = (r_state == BB8051_ST_IDLE);
  assign o_ram_rd_en = (r_state == BB8051_ST_ISSUE);
  assign o_out_valid = (r_state == BB8051_ST_DONE);
  assign o_src_out   = r_src;
  assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_bb8051_operand_fetch.sv
// Purpose : self-checking bench for bb8051_operand_fetch (NUM_SRC=3, 8-bit data/address).
// Latency : n/a.
// Backpressure: out_ready driven by the bench, including long stalls in DONE.
module tb_bb8051_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready;
  logic [8:0]  src_sel;
  logic [7:0]  op2_in, op3_in, acc_in, b_reg_in;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [7:0]  ram_rd_data = 8'h00;
  logic [23:0] src_out;
  logic        out_valid, out_ready, sel_err;

  always #5 clk = ~clk;

  bb8051_operand_fetch #(.DATA_W(8), .ADDR_W(8), .NUM_SRC(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_src_sel(src_sel), .i_op2_in(op2_in), .i_op3_in(op3_in),
    .i_acc_in(acc_in), .i_b_reg_in(b_reg_in),
    .o_ram_rd_en(ram_rd_en), .o_ram_rd_addr(ram_rd_addr), .i_ram_rd_data(ram_rd_data),
    .o_src_out(src_out), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_sel_err(sel_err)
  );

  // Internal RAM: registered read, data valid the cycle after the strobe.
  logic [7:0] mem [256];
  logic [7:0] rd_log [$];
  logic [7:0] exp_rd [$];
  int         pulse_viol = 0;
  logic       prev_en = 1'b0;

  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rd_data <= mem[ram_rd_addr];
      rd_log.push_back(ram_rd_addr);
    end
    if (ram_rd_en && prev_en) pulse_viol <= pulse_viol + 1;
    prev_en <= ram_rd_en;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

`ifdef BB8051_OPFETCH_INDIRECT_EN
  localparam logic [2:0] FL_CODE = 3'd6;
`else
  localparam logic [2:0] FL_CODE = 3'd5;
`endif

  // Reference: resolve each channel straight from the select-code meanings.
  task automatic model(input logic [8:0] sel, input logic [7:0] op2, op3, acc, b,
                       output logic [23:0] es, output logic ee, output int el);
    logic [7:0] v, p;
    es = '0; ee = 1'b0; el = 1;
    exp_rd.delete();
    for (int ch = 0; ch < 3; ch++) begin
      v = 8'h00;
      case (sel[3*ch +: 3])
        3'd0: v = 8'h00;
        3'd1: v = acc;
        3'd2: v = b;
        3'd3: v = op2;
        3'd4: v = op3;
        3'd5: begin v = mem[op2]; exp_rd.push_back(op2); el += 2; end
`ifdef BB8051_OPFETCH_INDIRECT_EN
        3'd6: begin p = mem[op2]; v = mem[p]; exp_rd.push_back(op2); exp_rd.push_back(p); el += 4; end
`else
        3'd6: begin v = 8'h00; ee = 1'b1; end
`endif
        default: begin v = 8'h00; ee = 1'b1; end
      endcase
      es[8*ch +: 8] = v;
    end
  endtask

  // Call at a negedge with the block idle; returns #1 after the accept edge.
  task automatic start_txn(input logic [8:0] sel, input logic [7:0] op2, op3, acc, b);
    check("accept_ready", req_ready, 1);
    src_sel = sel; op2_in = op2; op3_in = op3; acc_in = acc; b_reg_in = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    src_sel = 9'($urandom); op2_in = 8'($urandom); op3_in = 8'($urandom);
    acc_in = 8'($urandom); b_reg_in = 8'($urandom);
  endtask

  task automatic finish_txn(input string nm, input logic [23:0] es, input logic ee,
                            input int el, input int base, input int hold);
    int lat, unstable;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, el);
    check({nm, "_src_out"}, src_out, es);
    check({nm, "_sel_err"}, sel_err, ee);
    check({nm, "_req_ready_busy"}, req_ready, 0);
    check({nm, "_num_reads"}, rd_log.size() - base, exp_rd.size());
    for (int k = 0; k < exp_rd.size(); k++) begin
      if (base + k < rd_log.size()) check({nm, "_rd_addr"}, rd_log[base + k], exp_rd[k]);
    end
    unstable = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      req_valid = 1'b1; src_sel = 9'($urandom); acc_in = 8'($urandom); op2_in = 8'($urandom);
      @(posedge clk); #1;
      if (src_out !== es || out_valid !== 1'b1 || req_ready !== 1'b0 ||
          sel_err !== ee || ram_rd_en !== 1'b0) unstable++;
    end
    if (hold > 0) check({nm, "_hold_unstable_cycles"}, unstable, 0);
    @(negedge clk);
    req_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_out_valid_after_hs"}, out_valid, 0);
    check({nm, "_req_ready_after_hs"}, req_ready, 1);
    check({nm, "_reads_total"}, rd_log.size() - base, exp_rd.size());
  endtask

  typedef struct {
    logic [8:0]  sel;
    logic [7:0]  op2, op3, acc, b;
    logic [23:0] src;
    logic        err;
    int          lat;
    int          nrd;
    logic [31:0] rda;   // expected read addresses, first in bits [7:0]
  } vec_t;

  function automatic vec_t mk(input logic [8:0] sel, input logic [7:0] op2, op3, acc, b,
                              input logic [23:0] src, input logic err, input int lat,
                              input int nrd, input logic [31:0] rda);
    vec_t v;
    v.sel = sel; v.op2 = op2; v.op3 = op3; v.acc = acc; v.b = b;
    v.src = src; v.err = err; v.lat = lat; v.nrd = nrd; v.rda = rda;
    return v;
  endfunction

  function automatic logic [8:0] s3(input logic [2:0] c2, c1, c0);
    return {c2, c1, c0};
  endfunction

  task automatic load_rd(input int nrd, input logic [31:0] rda);
    exp_rd.delete();
    for (int k = 0; k < nrd; k++) exp_rd.push_back(rda[8*k +: 8]);
  endtask

  vec_t vt [6];

  initial begin
    int base, el;
    logic [23:0] es;
    logic ee;
    logic [8:0] sel;
    logic [7:0] o2, o3, ac, bb;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h40] = 8'hC7; mem[8'h10] = 8'h80; mem[8'h80] = 8'h99;

    vt[0] = mk(s3(3'd0, 3'd3, 3'd1), 8'h33, 8'h11, 8'h5A, 8'h22, 24'h00335A, 1'b0, 1, 0, 32'h0);
    vt[1] = mk(s3(3'd0, 3'd0, 3'd5), 8'h40, 8'h00, 8'h00, 8'h00, 24'h0000C7, 1'b0, 3, 1, 32'h40);
`ifdef BB8051_OPFETCH_INDIRECT_EN
    vt[2] = mk(s3(3'd0, 3'd6, 3'd0), 8'h10, 8'h00, 8'h00, 8'h00, 24'h009900, 1'b0, 5, 2, 32'h8010);
    vt[5] = mk(s3(3'd5, 3'd1, 3'd6), 8'h10, 8'h00, 8'h01, 8'h00, 24'h800199, 1'b0, 7, 3, 32'h108010);
`else
    vt[2] = mk(s3(3'd0, 3'd6, 3'd0), 8'h10, 8'h00, 8'h00, 8'h00, 24'h000000, 1'b1, 1, 0, 32'h0);
    vt[5] = mk(s3(3'd5, 3'd1, 3'd6), 8'h10, 8'h00, 8'h01, 8'h00, 24'h800100, 1'b1, 3, 1, 32'h10);
`endif
    vt[3] = mk(s3(3'd7, 3'd4, 3'd2), 8'h01, 8'hC3, 8'h00, 8'hBB, 24'h00C3BB, 1'b1, 1, 0, 32'h0);
    vt[4] = mk(s3(3'd5, 3'd5, 3'd5), 8'h40, 8'h00, 8'h00, 8'h00, 24'hC7C7C7, 1'b0, 7, 3, 32'h404040);

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    src_sel = '0; op2_in = '0; op3_in = '0; acc_in = '0; b_reg_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_out", src_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_ram_rd_en", ram_rd_en, 0);
    check("rst_ram_rd_addr", ram_rd_addr, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      base = rd_log.size();
      load_rd(vt[t].nrd, vt[t].rda);
      start_txn(vt[t].sel, vt[t].op2, vt[t].op3, vt[t].acc, vt[t].b);
      finish_txn($sformatf("vec%0d", t), vt[t].src, vt[t].err, vt[t].lat, base, 0);
    end

    // out_ready held low for 10 cycles in DONE with a competing request.
    @(negedge clk);
    base = rd_log.size();
    load_rd(1, 32'h40);
    start_txn(s3(3'd7, 3'd1, 3'd5), 8'h40, 8'h00, 8'h3C, 8'h00);
    finish_txn("hold", 24'h003CC7, 1'b1, 3, base, 10);

    // Flush during CAPT: src_out keeps the accept-time values, late RAM data ignored.
    @(negedge clk);
    base = rd_log.size();
    load_rd(0, 32'h0);
    start_txn(s3(3'd0, 3'd4, 3'd0), 8'h00, 8'h5E, 8'h00, 8'h00);
    finish_txn("pre_flush", 24'h005E00, 1'b0, 1, base, 0);
    @(negedge clk);
    start_txn(s3(3'd7, FL_CODE, 3'd1), 8'h10, 8'h00, 8'h77, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("flush_sel_err_before", sel_err, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_sel_err", sel_err, 0);
    check("flush_req_ready", req_ready, 1);
    check("flush_ram_rd_en", ram_rd_en, 0);
    repeat (4) @(posedge clk);
    #1;
    check("flush_src_out_kept", src_out, 24'h005E77);
    check("flush_still_idle", out_valid, 0);
    @(negedge clk);
    base = rd_log.size();
    load_rd(vt[5].nrd, vt[5].rda);
    start_txn(vt[5].sel, vt[5].op2, vt[5].op3, vt[5].acc, vt[5].b);
    finish_txn("post_flush", vt[5].src, vt[5].err, vt[5].lat, base, 0);

    // Reset while a direct read is in ISSUE, then accept in the very next cycle.
    @(negedge clk);
    start_txn(s3(3'd7, 3'd0, 3'd5), 8'h40, 8'h00, 8'h00, 8'h00);
    check("mid_rst_issue_en", ram_rd_en, 1);
    check("mid_rst_sel_err_before", sel_err, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_src_out", src_out, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sel_err", sel_err, 0);
    check("mid_rst_ram_rd_en", ram_rd_en, 0);
    check("mid_rst_ram_rd_addr", ram_rd_addr, 0);
    check("mid_rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    base = rd_log.size();
    load_rd(1, 32'h40);
    start_txn(s3(3'd0, 3'd1, 3'd5), 8'h40, 8'h00, 8'hAB, 8'h00);
    finish_txn("post_rst", 24'h00ABC7, 1'b0, 3, base, 0);

    // Randomised transactions against the reference model.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 60; t++) begin
      sel = 9'($urandom); o2 = 8'($urandom); o3 = 8'($urandom);
      ac = 8'($urandom); bb = 8'($urandom);
      model(sel, o2, o3, ac, bb, es, ee, el);
      @(negedge clk);
      base = rd_log.size();
      start_txn(sel, o2, o3, ac, bb);
      finish_txn("rand", es, ee, el, base, $urandom_range(0, 3));
    end

    check("rd_en_single_cycle_pulses", pulse_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
